pipe_stage_skid: RTL

- Parametrised inter-stage pipeline register that replaces the fixed, always-enabled stage latches (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bundle with a valid/ready handshake, synchronous flush for exception and branch squash, and an optional 2-entry skid buffer.
- The skid buffer keeps in_ready registered, so downstream back-pressure (cache miss, multi-cycle div) does not form a long combinational path.
- Includes a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 62 ++++++
 rtl/pipe_stage_skid_sat_counter.sv | 22 ++
 rtl/pipe_stage_skid.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared stage payload bundles and the occupancy-coded state encoding for pipe_stage_skid.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic [1:0]  mem_width;
    logic [31:0] phy_addr;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [1:0]  hilo_out;
    logic        cp0_to_reg;
    logic [31:0] cp0_data;
    logic [31:0] pc;
    logic [31:0] bad_vaddr;
    logic [7:0]  exception_type;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [1:0]  hilo_out;
    logic        cp0_to_reg;
    logic [31:0] cp0_data;
    logic [31:0] pc;
  } mem_wb_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic [1:0]  mem_width;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [1:0]  hilo_out;
    logic        cp0_to_reg;
    logic [31:0] pc;
    logic [7:0]  exception_type;
  } id_ex_t;

  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid, flush and stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = 256,
  parameter bit          SKID           = 1'b1,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  stage_state_t      state;
  stage_state_t      state_n;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              push;
  logic              pop;
  logic              main_load_in;
  logic              main_load_skid;
  logic              skid_load;
  logic              clear;

  assign out_valid = (state != EMPTY);
  assign occupancy = 2'(state);
  assign out_data  = main_q;
  assign in_ready  = SKID ? in_ready_q : (~out_valid | out_ready);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign clear     = flush & CLEAR_ON_FLUSH;

  // Next state and payload load strobes; flush overrides everything.
  always_comb begin
    state_n        = state;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          main_load_in = 1'b1;
          state_n      = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_load_in = 1'b1;
        end else if (push) begin
          if (SKID) begin
            skid_load = 1'b1;
            state_n   = TWO;
          end
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_load_skid = 1'b1;
          state_n        = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n        = EMPTY;
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  // in_ready_q looks one state ahead so the upstream never sees a combinational path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
    end else if (clear) begin
      main_q <= '0;
    end else if (main_load_in) begin
      main_q <= in_data;
    end else if (main_load_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q <= '0;
    end else if (clear) begin
      skid_q <= '0;
    end else if (skid_load) begin
      skid_q <= in_data;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready & ~flush),
    .clr   (stall_clr),
    .count (stall_cnt)
  );

endmodule
